// File: rtl/accum_pkg.sv
// Shared definitions for the accumulator ALU.
//   op_t        : 3-bit operation code carried on the accumulator's op port.
//   OP_W        : width of the opcode field.
//   op_counted(): 1 for opcodes that advance op_count (everything but NOP and
//                 the two reserved codes).
package accum_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NOP   = 3'b000,
    OP_ADD   = 3'b001,
    OP_SUB   = 3'b010,
    OP_LOAD  = 3'b011,
    OP_CLEAR = 3'b100,
    OP_UNDO  = 3'b101,
    OP_RSV6  = 3'b110,
    OP_RSV7  = 3'b111
  } op_t;

  function automatic logic op_counted(input op_t op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_LOAD) ||
           (op == OP_CLEAR) || (op == OP_UNDO);
  endfunction

endpackage

// File: rtl/accum_history.sv
// Undo history: a LIFO of up to DEPTH accumulator snapshots. When full, a push
// overwrites the oldest entry so the newest DEPTH values are always kept.
//   clk, rst_n : clock, async active-low reset (empties the history)
//   push_i     : store data_i as the newest entry
//   pop_i      : discard the newest entry (caller guarantees non-empty)
//   data_i     : value to push
//   data_o     : newest entry (valid when empty_o=0)
//   empty_o    : no entries held
//   full_o     : DEPTH entries held
module accum_history #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    ptr_q;  // next slot to write
  logic [CW-1:0]    cnt_q;
  logic [PW-1:0]    top_idx;
  logic [PW-1:0]    nxt_idx;

  // Pointer arithmetic wraps modulo DEPTH, which need not be a power of two.
  assign top_idx = (ptr_q == '0) ? PW'(DEPTH - 1) : ptr_q - PW'(1);
  assign nxt_idx = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);

  assign data_o  = mem_q[top_idx];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (push_i) begin
      mem_q[ptr_q] <= data_i;
      ptr_q        <= nxt_idx;
      if (!full_o) cnt_q <= cnt_q + CW'(1);
    end else if (pop_i) begin
      ptr_q <= top_idx;
      cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/accumulator_alu_n.sv
// Accumulator ALU with add/sub/load/clear, optional signed saturation, and a
// bounded undo history.
//   clk, reset  : clock, async active-low reset
//   in_valid    : op/A sampled on a rising edge only when 1
//   op, A       : operation code and operand
//   clear_flags : clears ovf_sticky (a same-cycle overflow wins)
//   S           : registered accumulator
//   carry       : ADD carry-out / SUB no-borrow of the last accepted op
//   overflow    : signed overflow of the last accepted op
//   ovf_sticky  : latched overflow
//   undo_err    : one-cycle pulse on UNDO with empty history
//   op_count    : wrapping count of accepted non-NOP ops
module accumulator_alu_n
  import accum_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int SAT_EN = 0,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  op_t              op,
  input  logic [WIDTH-1:0] A,
  input  logic             clear_flags,
  output logic [WIDTH-1:0] S,
  output logic             carry,
  output logic             overflow,
  output logic             ovf_sticky,
  output logic             undo_err,
  output logic [CNT_W-1:0] op_count
);

  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             sticky_q, sticky_d;
  logic             uerr_q, uerr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH:0]   sum_add;
  logic [WIDTH:0]   sum_sub;
  logic [WIDTH-1:0] sat_val;
  logic             push, pop;
  logic [WIDTH-1:0] hist_data;
  logic             hist_empty;
  logic             hist_full_unused;

  assign sum_add = {1'b0, s_q} + {1'b0, A};
  assign sum_sub = {1'b0, s_q} + {1'b0, ~A} + (WIDTH+1)'(1);

  // Signed overflow always moves away from S's sign, so S's sign picks the rail.
  assign sat_val = s_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                : {1'b0, {(WIDTH-1){1'b1}}};

  accum_history #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_history (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (s_q),
    .data_o  (hist_data),
    .empty_o (hist_empty),
    .full_o  (hist_full_unused)
  );

  always_comb begin
    s_d      = s_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    sticky_d = sticky_q & ~clear_flags;
    uerr_d   = 1'b0;
    cnt_d    = cnt_q;
    push     = 1'b0;
    pop      = 1'b0;
    if (in_valid) begin
      if (op_counted(op)) cnt_d = cnt_q + CNT_W'(1);
      case (op)
        OP_ADD: begin
          push     = 1'b1;
          carry_d  = sum_add[WIDTH];
          ovf_d    = (s_q[WIDTH-1] == A[WIDTH-1]) &&
                     (sum_add[WIDTH-1] != s_q[WIDTH-1]);
          s_d      = (ovf_d && SAT_EN != 0) ? sat_val : sum_add[WIDTH-1:0];
          sticky_d = sticky_d | ovf_d;
        end
        OP_SUB: begin
          push     = 1'b1;
          carry_d  = sum_sub[WIDTH];
          ovf_d    = (s_q[WIDTH-1] != A[WIDTH-1]) &&
                     (sum_sub[WIDTH-1] != s_q[WIDTH-1]);
          s_d      = (ovf_d && SAT_EN != 0) ? sat_val : sum_sub[WIDTH-1:0];
          sticky_d = sticky_d | ovf_d;
        end
        OP_LOAD: begin
          push    = 1'b1;
          s_d     = A;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
        end
        OP_CLEAR: begin
          push    = 1'b1;
          s_d     = '0;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
        end
        OP_UNDO: begin
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          if (hist_empty) begin
            uerr_d = 1'b1;
          end else begin
            pop = 1'b1;
            s_d = hist_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_q      <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      sticky_q <= 1'b0;
      uerr_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s_q      <= s_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      sticky_q <= sticky_d;
      uerr_q   <= uerr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign S          = s_q;
  assign carry      = carry_q;
  assign overflow   = ovf_q;
  assign ovf_sticky = sticky_q;
  assign undo_err   = uerr_q;
  assign op_count   = cnt_q;

endmodule

// File: tb/tb_accumulator_alu_n.sv
module tb_accumulator_alu_n;
  import accum_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  op_t        op = OP_NOP;
  logic [7:0] A = '0;
  logic       clear_flags = 1'b0;

  // dut0: wrap mode, 8-bit count
  logic [7:0] s0;  logic c0, v0, st0, ue0;  logic [7:0] n0;
  // dut1: saturating
  logic [7:0] s1;  logic c1, v1, st1, ue1;  logic [7:0] n1;
  // dut2: 4-bit op counter
  logic [7:0] s2;  logic c2, v2, st2, ue2;  logic [3:0] n2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  accumulator_alu_n #(.WIDTH(8), .DEPTH(4), .SAT_EN(0), .CNT_W(8)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .op(op), .A(A),
    .clear_flags(clear_flags), .S(s0), .carry(c0), .overflow(v0),
    .ovf_sticky(st0), .undo_err(ue0), .op_count(n0));

  accumulator_alu_n #(.WIDTH(8), .DEPTH(4), .SAT_EN(1), .CNT_W(8)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .op(op), .A(A),
    .clear_flags(clear_flags), .S(s1), .carry(c1), .overflow(v1),
    .ovf_sticky(st1), .undo_err(ue1), .op_count(n1));

  accumulator_alu_n #(.WIDTH(8), .DEPTH(4), .SAT_EN(0), .CNT_W(4)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .op(op), .A(A),
    .clear_flags(clear_flags), .S(s2), .carry(c2), .overflow(v2),
    .ovf_sticky(st2), .undo_err(ue2), .op_count(n2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; returns 1 ns after the sampling edge.
  task automatic step(input logic v, input op_t o, input logic [7:0] a, input logic clr);
    @(negedge clk);
    in_valid = v; op = o; A = a; clear_flags = clr;
    @(posedge clk);
    #1;
    in_valid = 1'b0; op = OP_NOP; clear_flags = 1'b0;
  endtask

  initial begin
    #2;
    check("rst_S", s0, 0);
    check("rst_cnt", n0, 0);
    check("rst_sticky", st0, 0);
    @(negedge clk); reset = 1'b1;

    // Wrap vs saturate on positive overflow
    step(1, OP_LOAD, 8'h7F, 0);
    check("load_7f", s0, 8'h7F);
    step(1, OP_ADD, 8'h01, 0);
    check("add_ovf_S", s0, 8'h80);
    check("add_ovf_v", v0, 1);
    check("add_ovf_c", c0, 0);
    check("add_ovf_sticky", st0, 1);
    check("sat_pos_S", s1, 8'h7F);
    check("sat_pos_v", v1, 1);
    step(0, OP_NOP, 8'h00, 1);
    check("sticky_clr", st0, 0);
    check("hold_v_idle", v0, 1);

    // Negative overflow on SUB
    step(1, OP_LOAD, 8'h80, 0);
    step(1, OP_SUB, 8'h01, 0);
    check("sat_neg_S", s1, 8'h80);
    check("sat_neg_v", v1, 1);
    check("sat_neg_c", c1, 1);
    check("wrap_neg_S", s0, 8'h7F);
    step(1, OP_LOAD, 8'h05, 0);
    check("load_flags_v", v1, 0);
    step(1, OP_SUB, 8'h03, 0);
    check("sub_S", s1, 8'h02);
    check("sub_c", c1, 1);
    check("sub_v", v1, 0);
    step(1, OP_SUB, 8'h03, 0);
    check("sub_borrow_S", s0, 8'hFF);
    check("sub_borrow_c", c0, 0);

    // Set and clear in the same cycle: set wins
    step(0, OP_NOP, 8'h00, 1);
    check("sticky_pre", st0, 0);
    step(1, OP_LOAD, 8'h7F, 0);
    step(1, OP_ADD, 8'h01, 1);
    check("sticky_setclr", st0, 1);
    step(0, OP_NOP, 8'h00, 1);
    check("sticky_clr2", st0, 0);

    // Carry, then holds under NOP / reserved / in_valid=0
    step(1, OP_LOAD, 8'hFF, 0);
    step(1, OP_ADD, 8'h02, 0);
    check("add_carry_S", s0, 8'h01);
    check("add_carry_c", c0, 1);
    check("add_carry_v", v0, 0);
    step(1, OP_NOP, 8'h55, 0);
    check("nop_S", s0, 8'h01);
    check("nop_c", c0, 1);
    step(1, OP_RSV6, 8'h55, 0);
    check("rsv6_S", s0, 8'h01);
    check("rsv6_c", c0, 1);
    step(0, OP_ADD, 8'h55, 0);
    check("invalid_S", s0, 8'h01);

    // History depth 4 with circular overwrite
    step(1, OP_LOAD, 8'h01, 0);
    for (int i = 0; i < 4; i++) step(1, OP_ADD, 8'h01, 0);
    check("hist_top", s0, 8'h05);
    for (int i = 0; i < 4; i++) begin
      step(1, OP_UNDO, 8'h00, 0);
      check("undo_S", s0, 32'(4 - i));
      check("undo_err_lo", ue0, 0);
      check("undo_c", c0, 0);
    end
    step(1, OP_UNDO, 8'h00, 0);
    check("undo_empty_err", ue0, 1);
    check("undo_empty_S", s0, 8'h01);
    step(0, OP_NOP, 8'h00, 0);
    check("undo_err_pulse", ue0, 0);

    // Async reset mid-cycle with a valid op pending
    @(negedge clk);
    in_valid = 1'b1; op = OP_ADD; A = 8'h05;
    #2 reset = 1'b0;
    #1;
    check("arst_S", s0, 0);
    check("arst_cnt", n0, 0);
    check("arst_c", c0, 0);
    check("arst_v", v0, 0);
    @(posedge clk); #1;
    check("arst_hold_S", s0, 0);
    @(negedge clk); reset = 1'b1; in_valid = 1'b0;
    step(1, OP_UNDO, 8'h00, 0);
    check("arst_undo_err", ue0, 1);
    check("arst_undo_S", s0, 0);
    check("arst_undo_cnt", n0, 1);

    // Counter wrap on a 4-bit op_count; NOPs not counted
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step(1, OP_ADD, 8'h01, 0);
      step(1, OP_NOP, 8'h00, 0);
      if (i == 14) check("cnt4_15", n2, 4'hF);
    end
    check("cnt4_wrap", n2, 0);
    check("cnt8_16", n0, 8'h10);
    check("cnt_sum_S", s0, 8'h10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
